interp_rate_scheduler: RTL and testbench

//  Sequencer for the stereo linear-interpolation datapath. Measures input sample period, generates the
//  96 kHz output tick, derives the two interpolation coefficients, and time-shares ONE external
//  24x11 multiplier across L/R x 2 taps. Sits between the I2S/SPDIF receiver and the output filter

---
 rtl/interp_rate_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_interp_rate_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/interp_rate_scheduler.sv
// Stereo linear-interpolation sequencer: measures the input sample period, generates the output tick,
// derives c0/c1 and time-shares one external multiplier across L/R x two taps.
module interp_rate_scheduler #(
  parameter int OUT_DIV  = 512,
  parameter int MULT_LAT = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                din_en,
  input  logic signed [23:0]  l_data_in,
  input  logic signed [23:0]  r_data_in,
  output logic signed [23:0]  mult_a,
  output logic        [10:0]  mult_b,
  output logic                mult_ce,
  input  logic signed [34:0]  mult_p,
  output logic                dout_valid,
  output logic signed [35:0]  l_data_out,
  output logic signed [35:0]  r_data_out,
  output logic        [10:0]  coef_max,
  output logic                overrun_err
);

  localparam int DATA_W = 24;
  localparam int COEF_W = 11;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;
  localparam int TICK_W = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OUT_DIV - 1);
  localparam logic [3:0]        LAT_C     = 4'(MULT_LAT);
  localparam logic [3:0]        SEQ_LAST  = 4'(MULT_LAT + 3);
  localparam logic [COEF_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, CAPTURE, ISSUE, DRAIN, OUT} state_t;

  function automatic logic [1:0] norm_shift(input logic [COEF_W-1:0] p);
    if (p < COEF_W'(384)) return 2'd2;
    if (p < COEF_W'(768)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {p[PROD_W-1], p};
  endfunction

  state_t                    state;
  logic [COEF_W-1:0]         per_cnt, period, phase;
  logic [TICK_W-1:0]         tick_cnt;
  logic                      din_seen, primed, tick;
  logic [3:0]                seq_cnt;
  logic signed [DATA_W-1:0]  x0_l, x1_l, x0_r, x1_r;
  logic signed [DATA_W-1:0]  x0_r_p1, x1_l_p1, x1_r_p1;
  logic [COEF_W-1:0]         c0_p1, c1_p1, max_p1;
  logic signed [ACC_W-1:0]   acc_l_p2, acc_r_p2, acc_l_nxt, acc_r_nxt;
  logic [1:0]                shift;
  logic [COEF_W-1:0]         max_n, ph_n, c0, c1;
  logic                      prod_vld, prod_is_r;

  always_comb begin
    tick  = run && (tick_cnt == TICK_LAST);
    shift = norm_shift(period);
    max_n = period << shift;
    ph_n  = phase << shift;
    if (phase >= period) begin
      c0 = max_n;
      c1 = '0;
    end else begin
      c0 = ph_n;
      c1 = max_n - ph_n;
    end
    // Product k lands MULT_LAT cycles after ISSUE slot k; even k is left, odd k is right.
    prod_vld  = ((state == ISSUE) || (state == DRAIN)) && (seq_cnt >= LAT_C) && (seq_cnt <= SEQ_LAST);
    prod_is_r = seq_cnt[0] ^ LAT_C[0];
    acc_l_nxt = acc_l_p2;
    acc_r_nxt = acc_r_p2;
    if (prod_vld) begin
      if (prod_is_r) acc_r_nxt = acc_r_p2 + sext_prod(mult_p);
      else           acc_l_nxt = acc_l_p2 + sext_prod(mult_p);
    end
  end

  // Stage p0: input history; p1: operand snapshot at CAPTURE; p2: per-channel accumulators
  always_ff @(posedge clk) begin
    if (run && din_en) begin
      x1_l <= x0_l;
      x0_l <= l_data_in;
      x1_r <= x0_r;
      x0_r <= r_data_in;
    end
    if (state == CAPTURE) begin
      x0_r_p1  <= x0_r;
      x1_l_p1  <= x1_l;
      x1_r_p1  <= x1_r;
      c0_p1    <= c0;
      c1_p1    <= c1;
      max_p1   <= max_n;
      acc_l_p2 <= '0;
      acc_r_p2 <= '0;
    end else begin
      acc_l_p2 <= acc_l_nxt;
      acc_r_p2 <= acc_r_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      per_cnt     <= '0;
      period      <= '0;
      phase       <= '0;
      tick_cnt    <= '0;
      din_seen    <= 1'b0;
      primed      <= 1'b0;
      seq_cnt     <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      mult_ce     <= 1'b0;
      dout_valid  <= 1'b0;
      l_data_out  <= '0;
      r_data_out  <= '0;
      coef_max    <= '0;
      overrun_err <= 1'b0;
    end else if (!run) begin
      state      <= IDLE;
      per_cnt    <= '0;
      tick_cnt   <= '0;
      din_seen   <= 1'b0;
      primed     <= 1'b0;
      seq_cnt    <= '0;
      mult_ce    <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (din_en) begin
        per_cnt  <= '0;
        period   <= per_cnt;
        din_seen <= 1'b1;
        primed   <= primed | din_seen;
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + 1'b1;
      end
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) phase <= per_cnt;
      if (tick && (state != IDLE)) overrun_err <= 1'b1;

      case (state)
        IDLE: if (tick && primed) state <= CAPTURE;
        CAPTURE: begin
          state   <= ISSUE;
          seq_cnt <= '0;
          mult_a  <= x0_l;
          mult_b  <= c0;
          mult_ce <= 1'b1;
        end
        ISSUE: begin
          seq_cnt <= seq_cnt + 1'b1;
          case (seq_cnt[1:0])
            2'd0: begin mult_a <= x0_r_p1; mult_b <= c0_p1; end
            2'd1: begin mult_a <= x1_l_p1; mult_b <= c1_p1; end
            2'd2: begin mult_a <= x1_r_p1; mult_b <= c1_p1; end
            default: state <= DRAIN;
          endcase
        end
        DRAIN: begin
          seq_cnt <= seq_cnt + 1'b1;
          if (seq_cnt == SEQ_LAST) begin
            state      <= OUT;
            mult_ce    <= 1'b0;
            dout_valid <= 1'b1;
            l_data_out <= acc_l_nxt;
            r_data_out <= acc_r_nxt;
            coef_max   <= max_p1;
          end
        end
        OUT: begin
          dout_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_rate_scheduler.sv
// Randomized bench for interp_rate_scheduler: two instances (slow tick / overrunning tick) share one
// stimulus stream and are checked every cycle against an arithmetic reference model.
module tb_interp_rate_scheduler;

  localparam int NI    = 2;
  localparam int OD_A  = 64;
  localparam int LAT_A = 5;
  localparam int OD_B  = 8;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, run, din_en;
  logic signed [23:0] l_in, r_in;

  logic [NI-1:0][23:0] m_a;
  logic [NI-1:0][10:0] m_b;
  logic [NI-1:0]       m_ce;
  logic [NI-1:0][34:0] m_p;
  logic [NI-1:0]       dv;
  logic [NI-1:0][35:0] l_out, r_out;
  logic [NI-1:0][10:0] cmax;
  logic [NI-1:0]       ovr;

  interp_rate_scheduler #(.OUT_DIV(OD_A), .MULT_LAT(LAT_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .din_en(din_en),
    .l_data_in(l_in), .r_data_in(r_in),
    .mult_a(m_a[0]), .mult_b(m_b[0]), .mult_ce(m_ce[0]), .mult_p(m_p[0]),
    .dout_valid(dv[0]), .l_data_out(l_out[0]), .r_data_out(r_out[0]),
    .coef_max(cmax[0]), .overrun_err(ovr[0]));

  interp_rate_scheduler #(.OUT_DIV(OD_B), .MULT_LAT(LAT_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .din_en(din_en),
    .l_data_in(l_in), .r_data_in(r_in),
    .mult_a(m_a[1]), .mult_b(m_b[1]), .mult_ce(m_ce[1]), .mult_p(m_p[1]),
    .dout_valid(dv[1]), .l_data_out(l_out[1]), .r_data_out(r_out[1]),
    .coef_max(cmax[1]), .overrun_err(ovr[1]));

  // External multipliers: pipelines that advance only while ce is high
  function automatic logic signed [34:0] mul(input logic signed [23:0] a, input logic [10:0] b);
    logic signed [35:0] t;
    t = a * $signed({1'b0, b});
    return t[34:0];
  endfunction

  logic signed [34:0] pa [LAT_A];
  logic signed [34:0] pb [LAT_B];
  always @(posedge clk) begin
    if (m_ce[0]) begin
      pa[0] <= mul($signed(m_a[0]), m_b[0]);
      for (int k = 1; k < LAT_A; k++) pa[k] <= pa[k-1];
    end
    if (m_ce[1]) begin
      pb[0] <= mul($signed(m_a[1]), m_b[1]);
      for (int k = 1; k < LAT_B; k++) pb[k] <= pb[k-1];
    end
  end
  assign m_p[0] = pa[LAT_A-1];
  assign m_p[1] = pb[LAT_B-1];

  int n_checks, n_errors, cyc;
  bit last_rst;

  int     od [NI], lat [NI];
  int     m_per [NI], m_period [NI], m_tick [NI], m_dcnt [NI], m_T [NI], m_pmax [NI];
  bit     m_act [NI], m_ovr [NI];
  longint m_x0l [NI], m_x1l [NI], m_x0r [NI], m_x1r [NI], m_pl [NI], m_pr [NI];
  bit     e_valid [NI], e_ce [NI];
  longint e_l [NI], e_r [NI];
  int     e_max [NI];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: one clock edge of instance i, given the inputs currently driven.
  // m_act covers the cycles after a started tick in which the sequencer is not idle.
  task automatic step(input int i);
    bit tick, idle, primed;
    int phase, s, maxn, phn, c0, c1;
    if (!reset_n) begin
      m_per[i] = 0; m_period[i] = 0; m_tick[i] = 0; m_dcnt[i] = 0;
      m_act[i] = 0; m_ovr[i] = 0;
      m_x0l[i] = 0; m_x1l[i] = 0; m_x0r[i] = 0; m_x1r[i] = 0;
      e_valid[i] = 0; e_ce[i] = 0; e_l[i] = 0; e_r[i] = 0; e_max[i] = 0;
      return;
    end
    if (!run) begin
      m_per[i] = 0; m_tick[i] = 0; m_dcnt[i] = 0; m_act[i] = 0;
      e_valid[i] = 0; e_ce[i] = 0;
      return;
    end
    tick   = (m_tick[i] == od[i] - 1);
    idle   = !m_act[i];
    primed = (m_dcnt[i] >= 2);
    phase  = m_per[i];
    if (din_en) begin
      m_period[i] = m_per[i];
      m_per[i] = 0;
      m_x1l[i] = m_x0l[i]; m_x0l[i] = longint'(l_in);
      m_x1r[i] = m_x0r[i]; m_x0r[i] = longint'(r_in);
      if (m_dcnt[i] < 2) m_dcnt[i]++;
    end else if (m_per[i] < 2047) begin
      m_per[i]++;
    end
    m_tick[i] = tick ? 0 : m_tick[i] + 1;
    if (tick && !idle) m_ovr[i] = 1;
    if (m_act[i] && (cyc - m_T[i] == 6 + lat[i])) m_act[i] = 0;
    if (tick && idle && primed) begin
      s    = (m_period[i] < 384) ? 2 : (m_period[i] < 768) ? 1 : 0;
      maxn = (m_period[i] << s) & 2047;
      phn  = (phase << s) & 2047;
      if (phase >= m_period[i]) begin c0 = maxn; c1 = 0; end
      else begin c0 = phn; c1 = maxn - phn; end
      m_pl[i]   = m_x0l[i] * c0 + m_x1l[i] * c1;
      m_pr[i]   = m_x0r[i] * c0 + m_x1r[i] * c1;
      m_pmax[i] = maxn;
      m_act[i]  = 1;
      m_T[i]    = cyc;
    end
    e_valid[i] = m_act[i] && (cyc + 1 - m_T[i] == 6 + lat[i]);
    e_ce[i]    = m_act[i] && (cyc + 1 - m_T[i] >= 2) && (cyc + 1 - m_T[i] <= 5 + lat[i]);
    if (e_valid[i]) begin
      e_l[i] = m_pl[i]; e_r[i] = m_pr[i]; e_max[i] = m_pmax[i];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("dout_valid/%0d", i),  longint'(dv[i]), longint'(e_valid[i]));
      check_eq($sformatf("mult_ce/%0d", i),     longint'(m_ce[i]), longint'(e_ce[i]));
      check_eq($sformatf("overrun_err/%0d", i), longint'(ovr[i]), longint'(m_ovr[i]));
      check_eq($sformatf("l_data_out/%0d", i),  longint'($signed(l_out[i])), e_l[i]);
      check_eq($sformatf("r_data_out/%0d", i),  longint'($signed(r_out[i])), e_r[i]);
      check_eq($sformatf("coef_max/%0d", i),    longint'(cmax[i]), longint'(e_max[i]));
      if (last_rst) begin
        check_eq($sformatf("mult_a_rst/%0d", i), longint'(m_a[i]), 0);
        check_eq($sformatf("mult_b_rst/%0d", i), longint'(m_b[i]), 0);
      end
    end
  endtask

  function automatic logic signed [23:0] rand_sample();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: return 24'sh800000;
      1: return 24'sh7FFFFF;
      default: begin
        r = $urandom;
        return $signed(r[23:0]);
      end
    endcase
  endfunction

  task automatic apply(input bit rn, input bit r, input bit d);
    reset_n = rn;
    run     = r;
    din_en  = d;
    if (d) begin
      l_in = rand_sample();
      r_in = rand_sample();
    end
    step(0);
    step(1);
    last_rst = !rn;
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  int  iv_tab [8];
  int  ivl, jit, nxt, run_hold;
  bit  drop_done, rst_done, r_s, rn_s, d_s;

  initial begin
    reset_n = 1'b0; run = 1'b0; din_en = 1'b0; l_in = '0; r_in = '0;
    n_checks = 0; n_errors = 0; cyc = 0; last_rst = 0;
    od[0] = OD_A; lat[0] = LAT_A;
    od[1] = OD_B; lat[1] = LAT_B;
    iv_tab = '{100, 384, 385, 600, 768, 769, 1025, 2300};
    drop_done = 0; rst_done = 0; run_hold = 0; nxt = 1;

    repeat (3) apply(1'b0, 1'b0, 1'b0);

    for (int seg = 0; seg < 12; seg++) begin
      ivl = iv_tab[(seg < 8) ? seg : $urandom_range(0, 7)];
      jit = (seg % 2 == 1) ? 60 : 0;
      for (int k = 0; k < 2500; k++) begin
        rn_s = 1'b1;
        r_s  = 1'b1;
        d_s  = 1'b0;
        nxt--;
        if (nxt <= 0) begin
          d_s = 1'b1;
          nxt = ivl + $urandom_range(0, jit);
        end
        if (seg >= 3 && !drop_done && m_act[0] && (cyc - m_T[0] == 7)) begin
          r_s = 1'b0;
          drop_done = 1;
        end
        if (seg >= 6 && !rst_done && m_act[0] && (cyc - m_T[0] == 3)) begin
          rn_s = 1'b0;
          rst_done = 1;
        end
        if (run_hold > 0) begin
          r_s = 1'b0;
          run_hold--;
        end else if ($urandom_range(0, 1999) == 0) begin
          run_hold = $urandom_range(1, 3);
        end
        apply(rn_s, r_s, d_s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
